// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered WIDTH-bit logic unit with valid/ready handshakes and burst folding.
// A burst's true beat count saturates at 2^CNT_W-1; y_sat marks bursts that went past it.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic [1:0]       acc_fn,
    input  logic             last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] y_cnt,
    output logic             y_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t           state;
    logic [WIDTH-1:0] acc, r, f;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       fn;
    logic             sat, sat_nx, cnt_max, accept, emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = state == ACCUM;
    assign emit     = !acc_en || last;
    assign cnt_max  = &cnt;
    assign cnt_nx   = cnt_max ? cnt : cnt + 1'b1;
    assign sat_nx   = sat || cnt_max;

    always_comb begin
        r = op == 3'd0 ? a & b :
            op == 3'd1 ? a | b :
            op == 3'd2 ? a ^ b :
            op == 3'd3 ? ~(a & b) :
            op == 3'd4 ? ~(a | b) :
            op == 3'd5 ? ~(a ^ b) :
            op == 3'd6 ? ~a : a;
        f = fn == 2'b01 ? acc | r :
            fn == 2'b10 ? acc ^ r : acc & r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            fn        <= 2'b00;
            y         <= '0;
            y_cnt     <= '0;
            y_sat     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (state == IDLE) begin
                    if (emit) begin
                        y         <= r;
                        y_cnt     <= CNT_W'(1);
                        y_sat     <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        acc   <= r;
                        cnt   <= CNT_W'(1);
                        sat   <= 1'b0;
                        fn    <= acc_fn;
                        state <= ACCUM;
                    end
                end else if (emit) begin
                    y         <= f;
                    y_cnt     <= cnt_nx;
                    y_sat     <= sat_nx;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    sat       <= 1'b0;
                end else begin
                    acc <= f;
                    cnt <= cnt_nx;
                    sat <= sat_nx;
                end
            end
        end
    end
endmodule
